// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one bit per clock,
// LSB first, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             sa_q;
    logic             sb_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             v_q;

    logic             diff_bit;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        diff_bit = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        res_d    = {diff_bit, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        cnt_q    <= '0;
                        sa_q     <= A[WIDTH-1];
                        sb_q     <= B[WIDTH-1];
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= borrow_d;
                    res_q    <= res_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // Publish the result on the same edge the last bit lands.
                        d_q     <= res_d;
                        bout_q  <= borrow_d;
                        v_q     <= (sa_q != sb_q) && (res_d[WIDTH-1] != sa_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
    assign V    = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, random ops vs an
// arithmetic model, held-start throughput, mid-run reset and a 16-bit instance.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bout;
    logic       v;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        bin16;
    logic        busy16;
    logic        done16;
    logic [15:0] d16;
    logic        bout16;
    logic        v16;

    int checks = 0;
    int passed = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(a), .B(b), .Bin(bin),
        .busy(busy), .done(done), .D(d), .Bout(bout), .V(v)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16),
        .A(a16), .B(b16), .Bin(bin16),
        .busy(busy16), .done(done16), .D(d16), .Bout(bout16), .V(v16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic mbin, output logic [7:0] md,
                                  output logic mbo, output logic mv);
        int ud;
        int sd;
        ud  = int'(ma) - int'(mb) - int'(mbin);
        sd  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        md  = ud[7:0];
        mbo = (ud < 0);
        mv  = (sd < -128) || (sd > 127);
    endfunction

    // Launch one op from IDLE and check the full busy/done timeline.
    task automatic run_op(input string nm, input logic [7:0] ta,
                          input logic [7:0] tb, input logic tbin,
                          input logic [7:0] ed, input logic eb,
                          input logic ev);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                if (!(busy === 1'b1 && done === 1'b0))
                    chk({nm, " busy"}, {30'd0, busy, done}, 32'h2);
            end
        end
        chk({nm, " done"}, {30'd0, busy, done}, 32'h1);
        chk({nm, " result"}, {22'd0, d, bout, v}, {22'd0, ed, eb, ev});
        @(posedge clk); #1;
        chk({nm, " idle"}, {30'd0, busy, done}, 32'h0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       v;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] md;
        logic       mbo;
        logic       mv;
        logic [7:0] prev_d;
        int         accepts[$];
        int         pulses;
        int         moved;
        logic       prev_busy;
        int         waited;
        logic       saw_done;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset8", {19'd0, busy, done, d, bout, v}, 32'h0);
        chk("reset16", {11'd0, busy16, done16, d16, bout16, v16}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].d, vecs[i].bo, vecs[i].v);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            if (i == 0) begin ra = 8'hFF; rb = 8'hFF; rbin = 1'b1; end
            model(ra, rb, rbin, md, mbo, mv);
            run_op($sformatf("rnd%0d", i), ra, rb, rbin, md, mbo, mv);
        end

        // start held high for 30 edges; operands scrambled outside IDLE.
        model(8'h33, 8'h11, 1'b1, md, mbo, mv);
        a = 8'h33; b = 8'h11; bin = 1'b1; start = 1'b1;
        prev_busy = 1'b0; pulses = 0; moved = 0; prev_d = d;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (busy && !prev_busy) accepts.push_back(c);
            prev_busy = busy;
            if (done) begin
                pulses++;
                chk($sformatf("held D@%0d", c), {23'd0, d, bout},
                    {23'd0, md, mbo});
            end else if (d !== prev_d) begin
                moved++;
            end
            prev_d = d;
            if (busy || done) begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end else begin
                a = 8'h33; b = 8'h11; bin = 1'b1;
            end
        end
        start = 1'b0;
        chk("held accepts", 32'(accepts.size()), 32'd3);
        if (accepts.size() == 3) begin
            chk("held acc0", 32'(accepts[0]), 32'd0);
            chk("held acc1", 32'(accepts[1]), 32'd10);
            chk("held acc2", 32'(accepts[2]), 32'd20);
        end
        chk("held pulses", 32'(pulses), 32'd3);
        chk("held D stable", 32'(moved), 32'd0);
        @(posedge clk); #1;

        // Reset during the 4th RUN cycle.
        a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort outs", {19'd0, busy, done, d, bout, v}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort quiet", {31'd0, saw_done}, 32'h0);
        run_op("post-reset", 8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1);

        // 16-bit instance: done exactly 16 edges after acceptance.
        a16 = 16'h0000; b16 = 16'h8000; bin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        waited = 0;
        while (!done16 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("w16 latency", 32'(waited), 32'd16);
        chk("w16 result", {13'd0, d16, bout16, v16},
            {13'd0, 16'h8000, 1'b1, 1'b1});
        @(posedge clk); #1;
        chk("w16 idle", {30'd0, busy16, done16}, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing D = A − B − Bin one bit per clock, LSB first, with a single borrow flip-flop carried between bit slices. It is the subtracting counterpart of the team's ripple adder chain and targets area-constrained datapaths where a full-width subtractor is too large. A start/busy/done handshake lets a controlling FSM launch one operation and collect the difference, borrow-out and signed-overflow flags.

## Interface

- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend, sampled on the accepting edge
- B  input  WIDTH  subtrahend, sampled on the accepting edge
- Bin  input  1  borrow-in, sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- D  output  WIDTH  difference, registered
- Bout  output  1  borrow-out of MSB slice (1 = unsigned A < B + Bin)
- V  output  1  signed overflow

## Operation

- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, load shift registers a←A, b←B, borrow←Bin, bit counter←0, capture sign bits A[WIDTH−1], B[WIDTH−1]; go to RUN. Otherwise stay.
- RUN, per edge: d = a[0] ^ b[0] ^ borrow; borrow ← (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow); d shifts into the working result register at MSB (shift right); a, b shift right; counter increments. After the WIDTH-th RUN edge, go to DONE.
- On entering DONE: D ← working result, Bout ← final borrow, V ← (signA ≠ signB) & (D[WIDTH−1] ≠ signA). D, Bout and V are only written at this edge.
- DONE: done=1 for exactly one cycle; unconditionally go to IDLE on the next edge.
- start is ignored in RUN and DONE (no queuing). A, B and Bin may change freely after the accepting edge.
- D, Bout and V hold their values from the last completed operation until the next DONE entry, including throughout RUN.
- Counter width: clog2(WIDTH+1) bits; no wrap occurs within one operation.
- Reset (rst_n=0, at any time, including mid-RUN): state←IDLE; busy=0, done=0, D=0, Bout=0, V=0; shift registers, borrow and counter←0. An aborted operation produces no done pulse. After rst_n deasserts, the first rising edge with start=1 is accepted.

## Timing

- Accepting edge k (IDLE, start=1): busy=1 from after edge k.
- RUN occupies edges k+1 … k+WIDTH.
- After edge k+WIDTH: busy=0, done=1, new D/Bout/V visible.
- After edge k+WIDTH+1: done=0, state IDLE.
- Earliest next accepting edge: k+WIDTH+2; throughput is one operation per WIDTH+2 cycles.
- All outputs are registered; no combinational path exists from any input to any output.

## Test plan

- WIDTH=8, A=0x5A, B=0x3C, Bin=0, start pulsed at edge k: expect busy high for 8 cycles, done high only after edge k+8, D=0x1E, Bout=0, V=0.
- A=0x00, B=0x01, Bin=0: expect D=0xFF, Bout=1, V=0. A=0x00, B=0x00, Bin=1: expect D=0xFF, Bout=1, V=0. A=0x10, B=0x0F, Bin=1: expect D=0x00, Bout=0, V=0.
- Overflow: A=0x80, B=0x01 → D=0x7F, Bout=0, V=1. A=0x7F, B=0xFF → D=0x80, Bout=1, V=1.
- start held high continuously for 30 cycles with fixed operands: expect accepting edges at k, k+10 and k+20 only; one done pulse per operation; D stable between pulses; operands changed during RUN do not affect the result.
- rst_n driven low for 1 cycle during the 4th RUN cycle: expect all outputs to read 0 immediately, no done pulse, and state IDLE. A new operation with A=0xC8, B=0x64 then yields D=0x64, Bout=0, V=1.
- WIDTH=16, A=0x0000, B=0x8000: expect D=0x8000, Bout=1, V=1, with done exactly 16 edges after the accepting edge.
